// File: rtl/divider_pkg.sv
// Shared definitions for the EX-stage integer divider: function codes,
// bus widths and the FSM state encoding.
package divider_pkg;

    localparam int FUNCT_W  = 6;
    localparam int DATA_W   = 32;
    localparam int DDATA_W  = 2 * DATA_W;

    localparam logic [FUNCT_W-1:0] FUNCT_DIV  = 6'b011010;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_CALC = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

    function automatic logic is_signed_op(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) returning {remainder, quotient},
// one quotient bit per cycle, stalling the pipeline while busy.
module divider
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FUNCT_W-1:0]      funct,
    input  logic                    div_en,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   operand_1,
    input  logic [DATA_WIDTH-1:0]   operand_2,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    done,
    output logic                    stall_req
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    function automatic logic [DATA_WIDTH-1:0] neg_f(input logic [DATA_WIDTH-1:0] x);
        return (~x) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    div_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0]     dvs_q, dvs_d;
    logic [DATA_WIDTH:0]       rem_q, rem_d;
    logic                      signed_q, signed_d;
    logic                      neg_quo_q, neg_quo_d;
    logic                      neg_rem_q, neg_rem_d;
    logic [2*DATA_WIDTH-1:0]   result_q, result_d;
    logic                      done_q, done_d;

    logic                      op_signed_s;
    logic                      neg_1_s, neg_2_s;
    logic [DATA_WIDTH:0]       shift_s, diff_s, step_rem_s;
    logic                      qbit_s;
    logic [DATA_WIDTH-1:0]     step_dvd_s, quo_fix_s, rem_fix_s;

    // Operand magnitudes are only taken for signed divides with a negative operand.
    assign op_signed_s = is_signed_op(funct);
    assign neg_1_s     = op_signed_s & operand_1[DATA_WIDTH-1];
    assign neg_2_s     = op_signed_s & operand_2[DATA_WIDTH-1];

    // The 33-bit trial subtraction keeps the borrow in the top bit.
    assign shift_s    = {rem_q[DATA_WIDTH-1:0], dvd_q[DATA_WIDTH-1]};
    assign diff_s     = shift_s - {1'b0, dvs_q};
    assign qbit_s     = ~diff_s[DATA_WIDTH];
    assign step_rem_s = qbit_s ? diff_s : shift_s;
    assign step_dvd_s = {dvd_q[DATA_WIDTH-2:0], qbit_s};

    assign quo_fix_s = (signed_q && neg_quo_q) ? neg_f(step_dvd_s) : step_dvd_s;
    assign rem_fix_s = (signed_q && neg_rem_q) ? neg_f(step_rem_s[DATA_WIDTH-1:0])
                                               : step_rem_s[DATA_WIDTH-1:0];

    // Next-state, datapath update and stall request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        signed_d  = signed_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (div_en && !flush) begin
                    stall_req = 1'b1;
                    if (operand_2 == {DATA_WIDTH{1'b0}}) begin
                        state_d = DIV_ZERO;
                    end else begin
                        state_d   = DIV_CALC;
                        dvd_d     = neg_1_s ? neg_f(operand_1) : operand_1;
                        dvs_d     = neg_2_s ? neg_f(operand_2) : operand_2;
                        rem_d     = {(DATA_WIDTH+1){1'b0}};
                        cnt_d     = {CNT_W{1'b0}};
                        signed_d  = op_signed_s;
                        neg_quo_d = neg_1_s ^ neg_2_s;
                        neg_rem_d = neg_1_s;
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_ZERO: begin
                stall_req = 1'b1;
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d  = DIV_DONE;
                    result_d = {(2*DATA_WIDTH){1'b0}};
                    done_d   = 1'b1;
                end
            end
            DIV_CALC: begin
                stall_req = 1'b1;
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem_s;
                    dvd_d = step_dvd_s;
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_STEP) begin
                        state_d  = DIV_DONE;
                        result_d = {rem_fix_s, quo_fix_s};
                        done_d   = 1'b1;
                    end else begin
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers; done/result load on entry to DONE so they are valid during it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            dvd_q     <= {DATA_WIDTH{1'b0}};
            dvs_q     <= {DATA_WIDTH{1'b0}};
            rem_q     <= {(DATA_WIDTH+1){1'b0}};
            signed_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {(2*DATA_WIDTH){1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            signed_q  <= signed_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Multi-cycle integer divider for the EX stage; the inverse-operation companion of the combinational multiplier.
- Executes DIV (signed) and DIVU (unsigned) with one radix-2 restoring step per cycle.
- Returns {remainder, quotient} for the HI/LO write path.
- Holds the pipeline via stall_req while busy.

Parameters:
- DATA_WIDTH, 32, operand width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- funct  in  `FUNCT_BUS  selects `FUNCT_DIV (signed) or `FUNCT_DIVU (unsigned); sampled at start
- div_en  in  1  start request; honoured only in IDLE
- flush  in  1  cancels any in-flight operation
- operand_1  in  `DATA_BUS  dividend; sampled at start
- operand_2  in  `DATA_BUS  divisor; sampled at start
- result  out  `DOUBLE_DATA_BUS  {remainder[63:32], quotient[31:0]}
- done  out  1  one-cycle pulse; result valid
- stall_req  out  1  high from the start cycle until the cycle before done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter=0; result=64'h0; done=0; stall_req=0. A reset mid-operation aborts with no done.
- States: IDLE, ZERO, CALC, DONE.
- IDLE, div_en=1, flush=0, operand_2!=0:
  - Latch |operand_1| and |operand_2|. Magnitude (two's complement) is taken only for DIV when bit 31 is set.
  - Latch sign flags and the funct type.
  - Clear the 33-bit partial remainder and the counter. Go to CALC.
- IDLE, div_en=1, flush=0, operand_2==0: go to ZERO.
- IDLE, div_en=0: stay.
- stall_req is high combinationally in IDLE when div_en=1 and flush=0, and in ZERO and CALC. It is low in IDLE otherwise and in DONE.
- CALC, per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor. If non-negative, keep the difference and shift in 1; else restore and shift in 0.
  - counter++. After the 32nd step go to DONE.
- ZERO: next cycle goes to DONE with quotient=32'h0, remainder=32'h0.
- DONE, sign fixup for DIV:
  - quotient is negated if the operand signs differ.
  - remainder takes the sign of the dividend.
  - DIVU applies no fixup.
- DONE: result register loads; done=1 for exactly this cycle; go to IDLE. div_en in the DONE cycle is ignored. The next start is accepted in the following IDLE cycle, so back-to-back divides are legal.
- Latency: start in cycle 0; CALC cycles 1..32; done in cycle 33. Divide-by-zero: done in cycle 2.
- result holds its last value until the next DONE; it is not cleared at start.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF wraps to quotient 0x80000000, remainder 0; no exception.
- flush: from any state, go to IDLE next cycle with no done pulse and result unchanged. flush has priority over div_en in IDLE.
- Width rules:
  - Partial remainder is 33 bits to hold the subtract borrow.
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned.

Decomposition:
- `FUNCT_DIV, `FUNCT_DIVU go in funct.v.
- `DATA_BUS, `DOUBLE_DATA_BUS come from bus.v.
- State encodings (`DIV_IDLE/ZERO/CALC/DONE) go in a shared defines file next to bus.v.
- No sub-module; FSM and datapath in one module.

Test Plan:
- DIVU 100 / 7 -> done at cycle 33; result={32'd2, 32'd14}; stall_req high cycles 0..32.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1.
- DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}. DIV same operands -> {0, 0xFFFFFFFF} (-1/1). DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
- Divide by zero: DIVU 5 / 0 -> done at cycle 2, result 64'h0, stall_req high cycles 0..1.
- flush at cycle 10 of a DIVU -> no done; IDLE at cycle 11; result unchanged. A new DIVU 9 / 3 started at cycle 12 -> {0, 3} at cycle 45.
- rst_n low at cycle 15 mid-DIV -> outputs 0 immediately (async). Back-to-back DIVU with div_en held high -> second done exactly 34 cycles after the first.
